// File: rtl/prog_loader_if.sv
// Valid/ready word stream from the host into the boot loader.
// The source drives valid/data/last and the loader returns ready.
interface prog_loader_if #(
  parameter int DATA_W = 32
) ();
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready
  );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: streams the instruction segment into imem from address 0 and the
// data segment into dmem from DMEM_BASE, holding the CPU in reset until both are in.
//
//   state  | meaning
//   IDLE   | after reset, CPU held in reset, waiting for start
//   LOAD_I | accepting instruction words into imem
//   LOAD_D | accepting data words into dmem
//   RUN    | both segments loaded, CPU released, done asserted
//   ERR    | segment overflow, CPU held in reset, error asserted
module prog_loader #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_BASE  = 16,
  parameter int DMEM_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  prog_loader_if.slave      strm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   i_count,
  output logic [ADDR_W:0]   d_count
);

  localparam logic [ADDR_W:0]   I_CAP  = (ADDR_W+1)'(IMEM_WORDS);
  localparam logic [ADDR_W:0]   D_CAP  = (ADDR_W+1)'(DMEM_WORDS);
  localparam logic [ADDR_W-1:0] D_BASE = ADDR_W'(DMEM_BASE);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_I = 3'd1,
    LOAD_D = 3'd2,
    RUN    = 3'd3,
    ERR    = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic              xfer;
  logic [ADDR_W:0]   i_count_nx, d_count_nx;
  logic              imem_we_nx, dmem_we_nx;
  logic [ADDR_W-1:0] imem_addr_nx, dmem_addr_nx;
  logic [DATA_W-1:0] imem_wdata_nx, dmem_wdata_nx;
  logic              cpu_rst_n_nx, done_nx, error_nx;

  // ready depends on registered state only, so it never combinationally follows valid
  assign strm.s_ready = (state == LOAD_I) || (state == LOAD_D);
  assign xfer         = strm.s_valid && strm.s_ready;

  always_comb begin
    state_nx      = state;
    i_count_nx    = i_count;
    d_count_nx    = d_count;
    imem_we_nx    = 1'b0;
    imem_addr_nx  = imem_addr;
    imem_wdata_nx = imem_wdata;
    dmem_we_nx    = 1'b0;
    dmem_addr_nx  = dmem_addr;
    dmem_wdata_nx = dmem_wdata;

    case (state)
      IDLE, RUN, ERR: begin
        if (start) begin
          state_nx   = LOAD_I;
          i_count_nx = '0;
          d_count_nx = '0;
        end
      end
      LOAD_I: begin
        if (xfer) begin
          if (i_count == I_CAP) begin
            state_nx = ERR;
          end else begin
            imem_we_nx    = 1'b1;
            imem_addr_nx  = i_count[ADDR_W-1:0];
            imem_wdata_nx = strm.s_data;
            i_count_nx    = i_count + 1'b1;
            if (strm.s_last) state_nx = LOAD_D;
          end
        end
      end
      LOAD_D: begin
        if (xfer) begin
          if (d_count == D_CAP) begin
            state_nx = ERR;
          end else begin
            dmem_we_nx    = 1'b1;
            dmem_addr_nx  = D_BASE + d_count[ADDR_W-1:0];
            dmem_wdata_nx = strm.s_data;
            d_count_nx    = d_count + 1'b1;
            if (strm.s_last) state_nx = RUN;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    // status flags are registered decodes of the state being entered
    cpu_rst_n_nx = (state_nx == RUN);
    done_nx      = (state_nx == RUN);
    error_nx     = (state_nx == ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      i_count    <= '0;
      d_count    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      cpu_rst_n  <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_nx;
      i_count    <= i_count_nx;
      d_count    <= d_count_nx;
      imem_we    <= imem_we_nx;
      imem_addr  <= imem_addr_nx;
      imem_wdata <= imem_wdata_nx;
      dmem_we    <= dmem_we_nx;
      dmem_addr  <= dmem_addr_nx;
      dmem_wdata <= dmem_wdata_nx;
      cpu_rst_n  <= cpu_rst_n_nx;
      done       <= done_nx;
      error      <= error_nx;
    end
  end

endmodule
